// File: rtl/adder_accumulator.sv
// Frame accumulator: sums a fixed number of unsigned beats and presents the result with a sticky carry flag.
// AdderAnybits is the shared ripple-carry adder and is the only addition path in the accumulator.

module AdderAnybits #(
    parameter int width = 8
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] S,
    output logic             Cout
);

    logic [width:0] w_carry;

    assign w_carry[0] = 1'b0;

    // One full-adder cell per bit, carry rippling from the LSB upward.
    for (genvar i = 0; i < width; i++) begin : g_bit
        assign S[i]         = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_carry[width];

endmodule

module adder_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    AdderAnybits #(
        .width(WIDTH)
    ) u_adder (
        .A   (r_acc),
        .B   (in_data),
        .S   (w_sum),
        .Cout(w_cout)
    );

    // A zero-length frame skips ACCUM entirely and reports the cleared accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= len;
                        r_state <= (len != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_cout;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomized self-checking bench for adder_accumulator against an arithmetic frame model.

module tb_adder_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       busy;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] beatQ[$];

    adder_accumulator #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result of a frame is the plain integer total folded to 8 bits; a carry occurred somewhere iff the total reached 256.
    task automatic model(output logic [7:0] sum, output logic ovf);
        int total;
        total = 0;
        foreach (beatQ[k]) total += int'(beatQ[k]);
        sum = 8'(total % 256);
        ovf = (total >= 256);
    endtask

    task automatic drive_frame(input int n, input int gap, input int hold,
                               output logic [7:0] sum, output logic ovf, output int lat,
                               output int unstable, output logic validAfter, output bit timedOut);
        int w;
        timedOut = 0;
        unstable = 0;
        lat = 0;
        start = 1'b1;
        len = 4'(n);
        tick();
        start = 1'b0;
        len = 4'($urandom);
        foreach (beatQ[k]) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data = beatQ[k];
            w = 0;
            while (!in_ready && w < 20) begin
                tick();
                w++;
            end
            if (!in_ready) begin
                timedOut = 1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) timedOut = 1;
        sum = out_sum;
        ovf = out_ovf;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!out_valid || out_sum !== sum || out_ovf !== ovf) unstable++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        validAfter = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        testsRun += 5;
        if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (out_sum !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_out_sum got %0d want 0", out_sum); end
        if (out_ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_ovf got %b want 0", out_ovf); end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] s;
        logic o, va;
        int lat, uns;
        bit to;
        beatQ = '{8'd10, 8'd20, 8'd30};
        drive_frame(3, 0, 0, s, o, lat, uns, va, to);
        testsRun += 6;
        if (to !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_timeout got %b want 0", to); end
        if (s !== 8'd60) begin testsFailed++; $display("[TB] FAIL basic_sum got %0d want 60", s); end
        if (o !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_ovf got %b want 0", o); end
        if (lat != 0) begin testsFailed++; $display("[TB] FAIL basic_latency got %0d extra cycles want 0", lat); end
        if (va !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_valid_after got %b want 0", va); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic o, va;
        int lat, uns;
        bit to;
        beatQ = '{8'd200, 8'd100};
        drive_frame(2, 0, 0, s, o, lat, uns, va, to);
        testsRun += 2;
        if (s !== 8'd44 || to) begin testsFailed++; $display("[TB] FAIL ovf_sum got %0d want 44", s); end
        if (o !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_flag got %b want 1", o); end
        beatQ = '{8'd5};
        drive_frame(1, 0, 0, s, o, lat, uns, va, to);
        testsRun += 2;
        if (s !== 8'd5 || to) begin testsFailed++; $display("[TB] FAIL ovf_next_sum got %0d want 5", s); end
        if (o !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_cleared got %b want 0", o); end
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len = 4'd0;
        tick();
        start = 1'b0;
        testsRun += 5;
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL len0_valid got %b want 1", out_valid); end
        if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL len0_in_ready got %b want 0", in_ready); end
        if (out_sum !== 8'd0) begin testsFailed++; $display("[TB] FAIL len0_sum got %0d want 0", out_sum); end
        if (out_ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL len0_ovf got %b want 0", out_ovf); end
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL len0_busy got %b want 1", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        testsRun++;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL len0_valid_after got %b want 0", out_valid); end
    endtask

    task automatic test_gaps_backpressure();
        logic [7:0] s;
        logic o, va;
        int lat, uns;
        bit to;
        beatQ = '{8'd1, 8'd2, 8'd3, 8'd4};
        drive_frame(4, 2, 5, s, o, lat, uns, va, to);
        testsRun += 4;
        if (s !== 8'd10 || to) begin testsFailed++; $display("[TB] FAIL gaps_sum got %0d want 10", s); end
        if (uns != 0) begin testsFailed++; $display("[TB] FAIL gaps_stable got %0d unstable cycles want 0", uns); end
        if (lat != 0) begin testsFailed++; $display("[TB] FAIL gaps_latency got %0d want 0", lat); end
        if (va !== 1'b0) begin testsFailed++; $display("[TB] FAIL gaps_single_handshake got %b want 0", va); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        len = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd50;
        tick();
        in_valid = 1'b0;
        start = 1'b1;
        len = 4'd0;
        tick();
        start = 1'b0;
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ign_accum_ready got %b want 1", in_ready); end
        in_valid = 1'b1;
        in_data = 8'd60;
        tick();
        in_data = 8'd70;
        tick();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        testsRun += 2;
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL ign_done_valid got %b want 1", out_valid); end
        if (out_sum !== 8'd180) begin testsFailed++; $display("[TB] FAIL ign_done_sum got %0d want 180", out_sum); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        testsRun++;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL ign_valid_after got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic o, va;
        int lat, uns;
        bit to;
        start = 1'b1;
        len = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd11;
        tick();
        in_data = 8'd22;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        testsRun += 4;
        if (out_sum !== 8'd0) begin testsFailed++; $display("[TB] FAIL rstmid_sum got %0d want 0", out_sum); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_valid got %b want 0", out_valid); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        testsRun++;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_no_result got %b want 0", out_valid); end
        beatQ = '{8'd7};
        drive_frame(1, 0, 0, s, o, lat, uns, va, to);
        testsRun += 2;
        if (s !== 8'd7 || to) begin testsFailed++; $display("[TB] FAIL rstmid_next_sum got %0d want 7", s); end
        if (o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_next_ovf got %b want 0", o); end
    endtask

    task automatic test_random();
        logic [7:0] s, es;
        logic o, eo, va;
        int lat, uns, n;
        bit to;
        for (int f = 0; f < 25; f++) begin
            n = int'($urandom_range(0, 15));
            beatQ.delete();
            for (int k = 0; k < n; k++) beatQ.push_back(8'($urandom));
            model(es, eo);
            drive_frame(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), s, o, lat, uns, va, to);
            testsRun += 3;
            if (s !== es || to) begin testsFailed++; $display("[TB] FAIL rand_sum frame %0d len %0d got %0d want %0d", f, n, s, es); end
            if (o !== eo) begin testsFailed++; $display("[TB] FAIL rand_ovf frame %0d len %0d got %b want %b", f, n, o, eo); end
            if (lat != 0 || uns != 0 || va !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rand_timing frame %0d got lat %0d unstable %0d validAfter %b want 0 0 0", f, lat, uns, va);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_len_zero();
        test_gaps_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
